// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one UART tx line between
// NUM_REQ byte sources. Each accepted byte is framed as start bit, DATA_BITS
// data bits (LSB first) and STOP_BITS stop bits. Every bit boundary is taken
// from the external baud_tick strobe.
//
// Handshake: a requester holds req_valid and its req_data slice stable. The
// transfer happens in the cycle where req_valid[i] & req_ready[i] are both
// high. req_ready is one-hot, combinational, only ever high in IDLE and never
// while Reset is high.
module uart_tx_scheduler #(
    parameter  int NUM_REQ   = 2,
    parameter  int DATA_BITS = 8,
    parameter  int STOP_BITS = 1,
    localparam int GRANT_W   = $clog2(NUM_REQ)
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         baud_tick,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [GRANT_W-1:0]           grant_id
);

    localparam int BCW = $clog2(DATA_BITS);

    // ALIGN waits for the first tick after the handshake so that the start bit
    // is given a full bit period.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
    logic [GRANT_W-1:0]   last_grant_q, last_grant_d;

    logic                 found;
    logic [GRANT_W-1:0]   winner;
    int unsigned          idx;

    // Round-robin search that starts one past the last granted requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = GRANT_W'(idx);
            end
        end
    end

    // Next-state logic, framing and combinational ready.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        tx_d         = tx_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                // A tick arriving in IDLE, including one in the handshake
                // cycle, is deliberately ignored.
                tx_d = 1'b1;
                if (found && !Reset) begin
                    req_ready[winner] = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (GRANT_W'(i) == winner) begin
                            shift_d = req_data[i*DATA_BITS +: DATA_BITS];
                        end
                    end
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    state_d      = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register. Reset abandons any frame in flight and drives the line idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            tx_q         <= 1'b1;
            grant_id_q   <= '0;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_q         <= tx_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler. Instance a uses the default parameters.
// Instance b uses STOP_BITS=2. Inputs change 1 ns after each rising edge, and
// outputs are sampled at that same point.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst;
    logic        tick_a, tick_b;
    logic [1:0]  valid_a, valid_b;
    logic [15:0] data_a, data_b;
    logic [1:0]  ready_a, ready_b;
    logic        tx_a, tx_b;
    logic        busy_a, busy_b;
    logic        gid_a, gid_b;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(2), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .Clk       (clk),
        .Reset     (rst),
        .baud_tick (tick_a),
        .req_valid (valid_a),
        .req_data  (data_a),
        .req_ready (ready_a),
        .tx        (tx_a),
        .busy      (busy_a),
        .grant_id  (gid_a)
    );

    uart_tx_scheduler #(.NUM_REQ(2), .DATA_BITS(8), .STOP_BITS(2)) dut_b (
        .Clk       (clk),
        .Reset     (rst),
        .baud_tick (tick_b),
        .req_valid (valid_b),
        .req_data  (data_b),
        .req_ready (ready_b),
        .tx        (tx_b),
        .busy      (busy_b),
        .grant_id  (gid_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tick(input bit sel, input logic v);
        if (sel) tick_b = v;
        else     tick_a = v;
    endtask

    // Sends n ticks on instance a, with per-1 quiet cycles before each tick.
    task automatic tick_n_a(input int n, input int per);
        for (int t = 0; t < n; t++) begin
            for (int j = 0; j < per; j++) begin
                tick_a = (j == per - 1);
                step();
            end
        end
        tick_a = 1'b0;
    endtask

    // Entered just after the handshake edge, with the DUT in ALIGN. Checks the
    // ALIGN gap and then every bit of the frame, held for per cycles each.
    task automatic run_frame(input bit sel, input logic [7:0] d, input int align_wait,
                             input int per, input int nstop);
        logic [10:0] bits;
        int          nbits;
        bits  = {2'b11, d, 1'b0};
        nbits = 1 + 8 + nstop;
        for (int j = 0; j <= align_wait; j++) begin
            check_val("align_tx", sel ? tx_b : tx_a, 1);
            check_val("align_busy", sel ? busy_b : busy_a, 1);
            set_tick(sel, j == align_wait);
            step();
        end
        for (int b = 0; b < nbits; b++) begin
            for (int j = 0; j < per; j++) begin
                check_val($sformatf("bit%0d_tx", b), sel ? tx_b : tx_a, bits[b]);
                check_val($sformatf("bit%0d_busy", b), sel ? busy_b : busy_a, 1);
                set_tick(sel, j == per - 1);
                step();
            end
        end
        set_tick(sel, 1'b0);
        check_val("end_busy", sel ? busy_b : busy_a, 0);
        check_val("end_tx", sel ? tx_b : tx_a, 1);
    endtask

    initial begin
        rst     = 1'b1;
        tick_a  = 1'b0;
        tick_b  = 1'b0;
        valid_a = 2'b11;
        valid_b = 2'b00;
        data_a  = '0;
        data_b  = '0;

        // 1: reset held with both requests valid
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("rst_tx", tx_a, 1);
            check_val("rst_busy", busy_a, 0);
            check_val("rst_ready", ready_a, 0);
            check_val("rst_gid", gid_a, 0);
            check_val("rst_b_tx", tx_b, 1);
        end
        rst     = 1'b0;
        valid_a = 2'b00;
        step();

        // 2: single frame 8'hA5 from req0, tick every 4 cycles
        data_a[7:0] = 8'hA5;
        valid_a     = 2'b01;
        #1;
        check_val("t2_ready", ready_a, 2'b01);
        step();
        valid_a = 2'b00;
        check_val("t2_gid", gid_a, 0);
        check_val("t2_busy", busy_a, 1);
        run_frame(1'b0, 8'hA5, 3, 4, 1);
        check_val("t2_idle_ready", ready_a, 0);

        // 3: both requesters held valid, alternating grants
        rst = 1'b1;
        step();
        rst     = 1'b0;
        data_a  = {8'h22, 8'h11};
        valid_a = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("t3_ready%0d", k), ready_a, (k % 2) ? 2'b10 : 2'b01);
            step();
            check_val($sformatf("t3_gid%0d", k), gid_a, k % 2);
            if (k == 3) valid_a = 2'b00;
            run_frame(1'b0, (k % 2) ? 8'h22 : 8'h11, (k == 0) ? 3 : 2, 4, 1);
        end

        // 4: reset in the middle of data bit 3
        data_a  = 16'h0000;
        valid_a = 2'b01;
        #1;
        check_val("t4_ready", ready_a, 2'b01);
        step();
        valid_a = 2'b00;
        tick_n_a(5, 4);
        check_val("t4_bit3_tx", tx_a, 0);
        check_val("t4_bit3_busy", busy_a, 1);
        step();
        rst     = 1'b1;
        valid_a = 2'b11;
        step();
        check_val("t4_rst_tx", tx_a, 1);
        check_val("t4_rst_busy", busy_a, 0);
        check_val("t4_rst_ready", ready_a, 0);
        rst = 1'b0;
        #1;
        check_val("t4_post_ready", ready_a, 2'b01);
        step();
        check_val("t4_post_gid", gid_a, 0);
        check_val("t4_post_busy", busy_a, 1);
        valid_a = 2'b00;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        step();

        // 5: tick in the handshake cycle is ignored, two stop bits (instance b)
        data_b[7:0] = 8'h3C;
        valid_b     = 2'b01;
        tick_b      = 1'b1;
        #1;
        check_val("t5_ready", ready_b, 2'b01);
        step();
        tick_b  = 1'b0;
        valid_b = 2'b00;
        check_val("t5_gid", gid_b, 0);
        run_frame(1'b1, 8'h3C, 3, 4, 2);

        // 6: 50 tick periods with nothing requested
        for (int p = 0; p < 50; p++) begin
            for (int j = 0; j < 4; j++) begin
                check_val("t6_tx", tx_a, 1);
                check_val("t6_busy", busy_a, 0);
                check_val("t6_ready", ready_a, 0);
                tick_a = (j == 3);
                step();
            end
        end
        tick_a = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
